// File: rtl/regbank_sched_pkg.sv
// Shared types and helpers for the register-bank write scheduler.
// State encoding, write-counter width and a constant-evaluable clog2.
package regbank_sched_pkg;

  typedef enum logic [1:0] {
    SLEEP  = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2
  } sched_state_e;

  localparam int WR_CNT_W = 16;

  // Number of bits needed to encode 'value' distinct indices (value >= 2).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at ptr, wrapping modulo NREQ, and returns the first
// asserted requester as a one-hot grant plus its encoded index.
module rr_arbiter
  import regbank_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        grant,
  output logic [clog2(NREQ)-1:0] grant_idx
);

  localparam int IW = clog2(NREQ);

  logic found_s;

  // Rotating priority search: first requester at or after ptr wins.
  always_comb begin
    int cand;
    grant     = {NREQ{1'b0}};
    grant_idx = {IW{1'b0}};
    found_s   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end else begin
        cand = cand;
      end
      if (!found_s && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/regbank_wr_sched.sv
// Register-bank write scheduler.
// Arbitrates NREQ valid/ready requesters round-robin onto the single
// registered bank write port (bank_enable/bank_data) and counts writes.
// Optional macro CLKGATE_EN adds a SLEEP/WAKE/ACTIVE sequencer that drops
// gate_en after IDLE_HOLD idle cycles and reopens it before the next write;
// without it gate_en is tied high and ready may follow valid in the same cycle.
module regbank_wr_sched
  import regbank_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int IDLE_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DW-1:0]     req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   bank_enable,
  output logic [DW-1:0]          bank_data,
  output logic                   gate_en,
  output logic [clog2(NREQ)-1:0] grant_id,
  output logic [WR_CNT_W-1:0]    wr_count
);

  localparam int IW = clog2(NREQ);
  localparam logic [WR_CNT_W-1:0] WR_ONE = WR_CNT_W'(1);

  // Elaboration-time guard on the supported parameter ranges.
  if ((NREQ < 2) || (NREQ > 8) || (IDLE_HOLD < 1) || (DW < 1)) begin : g_param_check
    $error("regbank_wr_sched: unsupported parameter set");
  end

  logic [NREQ-1:0]     arb_grant_s;
  logic [IW-1:0]       arb_idx_s;
  logic                arb_open_s;
  logic                xfer_s;
  logic [DW-1:0]       win_data_s;
  logic [IW-1:0]       ptr_r;
  logic [IW-1:0]       ptr_next_s;
  logic                bank_enable_r;
  logic [DW-1:0]       bank_data_r;
  logic [IW-1:0]       grant_id_r;
  logic [WR_CNT_W-1:0] wr_count_r;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s)
  );

  // The arbiter only grants valid requesters, so ready is the grant masked by
  // whether the port is currently open for writes.
  assign req_ready = arb_grant_s & {NREQ{arb_open_s}};
  assign xfer_s    = |req_ready;

  // Winner data mux built as an AND-OR so no priority is implied.
  always_comb begin
    win_data_s = {DW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      win_data_s = win_data_s | (req_data[i*DW +: DW] & {DW{arb_grant_s[i]}});
    end
  end

  // Pointer moves to the slot after the winner, wrapping at NREQ-1.
  always_comb begin
    if (arb_idx_s == IW'(NREQ - 1)) begin
      ptr_next_s = {IW{1'b0}};
    end else begin
      ptr_next_s = arb_idx_s + IW'(1);
    end
  end

  // Write port, last-grant, write counter and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_enable_r <= 1'b0;
      bank_data_r   <= {DW{1'b0}};
      grant_id_r    <= {IW{1'b0}};
      wr_count_r    <= {WR_CNT_W{1'b0}};
      ptr_r         <= {IW{1'b0}};
    end else if (xfer_s) begin
      bank_enable_r <= 1'b1;
      bank_data_r   <= win_data_s;
      grant_id_r    <= arb_idx_s;
      wr_count_r    <= wr_count_r + WR_ONE;
      ptr_r         <= ptr_next_s;
    end else begin
      // Data, grant id and pointer hold their last values between writes.
      bank_enable_r <= 1'b0;
    end
  end

  assign bank_enable = bank_enable_r;
  assign bank_data   = bank_data_r;
  assign grant_id    = grant_id_r;
  assign wr_count    = wr_count_r;

`ifdef CLKGATE_EN
  localparam int IDLE_W = clog2(IDLE_HOLD + 1);

  sched_state_e      state_r;
  sched_state_e      state_next_s;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic [IDLE_W-1:0] idle_cnt_next_s;
  logic              gate_en_r;
  logic              idle_cycle_s;

  // An idle cycle has nobody asking and no write landing in the bank.
  assign idle_cycle_s = ~(|req_valid) & ~bank_enable_r;
  assign arb_open_s   = (state_r == ACTIVE);

  // Gate sequencer next-state: sleep after IDLE_HOLD idle cycles, wake on any valid.
  always_comb begin
    state_next_s    = state_r;
    idle_cnt_next_s = idle_cnt_r;
    case (state_r)
      SLEEP: begin
        idle_cnt_next_s = {IDLE_W{1'b0}};
        if (|req_valid) begin
          state_next_s = WAKE;
        end else begin
          state_next_s = SLEEP;
        end
      end
      WAKE: begin
        idle_cnt_next_s = {IDLE_W{1'b0}};
        state_next_s    = ACTIVE;
      end
      ACTIVE: begin
        if (idle_cycle_s) begin
          if (idle_cnt_r == IDLE_W'(IDLE_HOLD - 1)) begin
            state_next_s    = SLEEP;
            idle_cnt_next_s = {IDLE_W{1'b0}};
          end else begin
            state_next_s    = ACTIVE;
            idle_cnt_next_s = idle_cnt_r + IDLE_W'(1);
          end
        end else begin
          // A request on the expiry edge keeps the gate open.
          state_next_s    = ACTIVE;
          idle_cnt_next_s = {IDLE_W{1'b0}};
        end
      end
      default: begin
        state_next_s    = SLEEP;
        idle_cnt_next_s = {IDLE_W{1'b0}};
      end
    endcase
  end

  // Sequencer state, idle counter and registered clock-gate enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= SLEEP;
      idle_cnt_r <= {IDLE_W{1'b0}};
      gate_en_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      idle_cnt_r <= idle_cnt_next_s;
      gate_en_r  <= (state_next_s != SLEEP);
    end
  end

  assign gate_en = gate_en_r;
`else
  // Bank clock is never gated; the port is always open.
  assign arb_open_s = 1'b1;
  assign gate_en    = 1'b1;
`endif

endmodule

// File: tb/tb_regbank_wr_sched.sv
// Directed self-checking bench for regbank_wr_sched (NREQ=4, DW=8, IDLE_HOLD=4).
// Builds with or without CLKGATE_EN; expectations follow the selected build.
module tb_regbank_wr_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        bank_enable;
  logic [7:0]  bank_data;
  logic        gate_en;
  logic [1:0]  grant_id;
  logic [15:0] wr_count;

  int          n_checks;
  int          n_errors;
  logic [15:0] exp_wr;
  logic [1:0]  exp_g;
  logic [7:0]  first_data;
  int          remaining;

`ifdef CLKGATE_EN
  localparam logic       RST_GATE   = 1'b0;
  localparam logic       SLEEP_GATE = 1'b0;
  localparam logic [1:0] PTR_AFTER1 = 2'd3;
  localparam logic [1:0] MID_FIRST  = 2'd1;
`else
  localparam logic       RST_GATE   = 1'b1;
  localparam logic       SLEEP_GATE = 1'b1;
  localparam logic [1:0] PTR_AFTER1 = 2'd1;
  localparam logic [1:0] MID_FIRST  = 2'd3;
`endif

  regbank_wr_sched #(
    .NREQ      (4),
    .DW        (8),
    .IDLE_HOLD (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .bank_enable (bank_enable),
    .bank_data   (bank_data),
    .gate_en     (gate_en),
    .grant_id    (grant_id),
    .wr_count    (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Two-cycle wakeup out of SLEEP in the gated build; nothing otherwise.
  task automatic wake();
`ifdef CLKGATE_EN
    step();
    chk("wake_gate", 32'(gate_en), 32'd1);
    chk("wake_ready", 32'(req_ready), 32'd0);
    step();
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_wr    = 16'd0;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'd0;
    repeat (2) step();

    chk("rst_bank_enable", 32'(bank_enable), 32'd0);
    chk("rst_bank_data", 32'(bank_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_gate_en", 32'(gate_en), 32'(RST_GATE));

`ifdef CLKGATE_EN
    // Wakeup from SLEEP: WAKE one cycle, ready the next, write after that.
    rst_n = 1'b1;
    step();
    chk("sleep_gate", 32'(gate_en), 32'd0);
    req_valid       = 4'b0100;
    req_data[23:16] = 8'h5A;
    first_data      = 8'h5A;
    #1;
    chk("sleep_ready", 32'(req_ready), 32'd0);
    step();
    chk("wake_gate_t1", 32'(gate_en), 32'd1);
    chk("wake_ready_t1", 32'(req_ready), 32'd0);
    step();
    chk("active_ready_t1", 32'(req_ready), 32'h4);
    step();
    exp_wr = 16'd1;
    chk("t1_bank_enable", 32'(bank_enable), 32'd1);
    chk("t1_bank_data", 32'(bank_data), 32'h5A);
    chk("t1_grant_id", 32'(grant_id), 32'd2);
    chk("t1_wr_count", 32'(wr_count), 32'(exp_wr));
    req_valid = 4'b0000;
`else
    // Ungated: ready follows valid in the same cycle right after reset.
    req_valid      = 4'b0001;
    req_data[7:0]  = 8'h11;
    first_data     = 8'h11;
    rst_n          = 1'b1;
    #1;
    chk("ready_same_cycle", 32'(req_ready), 32'h1);
    chk("gate_tied", 32'(gate_en), 32'd1);
    step();
    exp_wr = 16'd1;
    chk("t6_bank_enable", 32'(bank_enable), 32'd1);
    chk("t6_bank_data", 32'(bank_data), 32'h11);
    chk("t6_grant_id", 32'(grant_id), 32'd0);
    chk("t6_wr_count", 32'(wr_count), 32'(exp_wr));
    req_valid = 4'b0000;
`endif
    step();
    chk("single_pulse", 32'(bank_enable), 32'd0);
    chk("data_held", 32'(bank_data), 32'(first_data));
    chk("count_held", 32'(wr_count), 32'(exp_wr));

    // Round-robin burst with all four requesters valid for 8 writes.
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'b1111;
    exp_g     = PTR_AFTER1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << exp_g));
      step();
      exp_wr = exp_wr + 16'd1;
      chk("rr_enable", 32'(bank_enable), 32'd1);
      chk("rr_grant", 32'(grant_id), 32'(exp_g));
      chk("rr_data", 32'(bank_data), 32'(8'hA0 + 8'(exp_g)));
      chk("rr_count", 32'(wr_count), 32'(exp_wr));
      exp_g = exp_g + 2'd1;
    end

    // Idle window: a valid arriving on the 4th idle cycle keeps the gate open.
    req_valid = 4'b0000;
    step();
    chk("burst_end", 32'(bank_enable), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_gate_open", 32'(gate_en), 32'd1);
    end
    req_valid = 4'b0001 << exp_g;
    #1;
    chk("late_ready", 32'(req_ready), 32'(4'b0001 << exp_g));
    step();
    exp_wr = exp_wr + 16'd1;
    chk("late_gate", 32'(gate_en), 32'd1);
    chk("late_enable", 32'(bank_enable), 32'd1);
    chk("late_grant", 32'(grant_id), 32'(exp_g));
    exp_g = exp_g + 2'd1;

    // Full idle window: gate closes exactly 4 cycles after enable falls.
    req_valid = 4'b0000;
    step();
    chk("idle_enable_low", 32'(bank_enable), 32'd0);
    chk("idle_gate_e1", 32'(gate_en), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_gate_pre", 32'(gate_en), 32'd1);
    end
    step();
    chk("idle_gate_close", 32'(gate_en), 32'(SLEEP_GATE));

    // Requesters 1 and 3 pending, then an asynchronous reset mid-stream.
    req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    req_valid = 4'b1010;
    wake();
    #1;
    chk("mid_ready", 32'(req_ready), 32'(4'b0001 << MID_FIRST));
    step();
    exp_wr = exp_wr + 16'd1;
    chk("mid_grant", 32'(grant_id), 32'(MID_FIRST));
    chk("mid_count", 32'(wr_count), 32'(exp_wr));
    #2;
    rst_n = 1'b0;
    #1;
    exp_wr = 16'd0;
    chk("async_enable", 32'(bank_enable), 32'd0);
    chk("async_count", 32'(wr_count), 32'd0);
    chk("async_gate", 32'(gate_en), 32'(RST_GATE));
    chk("async_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wake();
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h2);
    step();
    exp_wr = exp_wr + 16'd1;
    chk("post_rst_grant", 32'(grant_id), 32'd1);
    chk("post_rst_data", 32'(bank_data), 32'hD1);
    chk("post_rst_count", 32'(wr_count), 32'(exp_wr));
    #1;
    chk("post_rst_ready2", 32'(req_ready), 32'h8);
    step();
    exp_wr = exp_wr + 16'd1;
    chk("post_rst_grant2", 32'(grant_id), 32'd3);

    // Counter wrap: continuous writes up to 16'hFFFF, then one more.
    req_valid = 4'b1111;
    remaining = 32'hFFFF - int'(exp_wr);
    repeat (remaining) step();
    chk("count_max", 32'(wr_count), 32'hFFFF);
    step();
    chk("count_wrap", 32'(wr_count), 32'd0);
    chk("wrap_enable", 32'(bank_enable), 32'd1);
    req_valid = 4'b0000;
    step();
    chk("final_enable", 32'(bank_enable), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
